// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory: port 0 (CPU)
// has priority, port 1 (loader/DMA) is guaranteed service after STARVE_LIMIT losses.
module mem_arbiter #(
  parameter int Bits         = 16,
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   addr0,
  input  logic [AW-1:0]   addr1,
  input  logic [Bits-1:0] wdata0,
  input  logic [Bits-1:0] wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            ack0,
  output logic            ack1,
  output logic [Bits-1:0] rdata0,
  output logic [Bits-1:0] rdata1,
  output logic            mem_read,
  output logic            mem_write,
  output logic [AW-1:0]   mem_addr,
  output logic [Bits-1:0] mem_wdata,
  input  logic [Bits-1:0] mem_rdata,
  output logic            busy,
  output logic [1:0]      dbg_state,
  output logic [3:0]      dbg_starve_cnt
);

  // Handshake: a port presents req/we/addr/wdata and holds them until its
  // one-cycle ack; only the values seen at the IDLE arbitration edge are used.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  state_t            r_state;
  logic              r_sel1;
  logic              r_we;
  logic [3:0]        r_starve;
  logic              r_gnt0, r_gnt1, r_ack0, r_ack1;
  logic              r_mem_read, r_mem_write;
  logic [AW-1:0]     r_mem_addr;
  logic [Bits-1:0]   r_mem_wdata;
  logic [Bits-1:0]   r_rdata0, r_rdata1;

  logic              w_any;
  logic              w_pick1;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [Bits-1:0]   w_wdata;

  assign w_any   = req0 | req1;
  assign w_pick1 = req1 & (~req0 | (r_starve == C_LIMIT));
  assign w_we    = w_pick1 ? we1    : we0;
  assign w_addr  = w_pick1 ? addr1  : addr0;
  assign w_wdata = w_pick1 ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sel1      <= 1'b0;
      r_we        <= 1'b0;
      r_starve    <= 4'd0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel1      <= w_pick1;
            r_we        <= w_we;
            r_gnt0      <= ~w_pick1;
            r_gnt1      <= w_pick1;
            r_mem_addr  <= w_addr;
            r_mem_read  <= ~w_we;
            r_mem_write <= w_we;
            if (w_we) r_mem_wdata <= w_wdata;
            // Count only port-0 wins that made port 1 wait.
            if (w_pick1 || !req1) r_starve <= 4'd0;
            else if (r_starve != C_LIMIT) r_starve <= r_starve + 4'd1;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_state     <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!r_we) begin
            if (r_sel1) r_rdata1 <= mem_rdata;
            else        r_rdata0 <= mem_rdata;
          end
          r_ack0  <= ~r_sel1;
          r_ack1  <= r_sel1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0           = r_gnt0;
  assign gnt1           = r_gnt1;
  assign ack0           = r_ack0;
  assign ack1           = r_ack1;
  assign rdata0         = r_rdata0;
  assign rdata1         = r_rdata1;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign busy           = (r_state != S_IDLE);
  assign dbg_state      = r_state;
  assign dbg_starve_cnt = r_starve;

endmodule
